if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch stage at the receiving end of the EX redirect path: owns the PC, consumes `PCSrc`/`branch_addr` from EX, issues one-outstanding fetch requests to instruction memory over a valid/ready handshake, and presents fetched instructions to the IF/ID register. A redirect kills the current fetch and any in-flight response, and clears the output buffer.

## Interface
- `ADDR_WIDTH`, 32, PC / instruction address width
- `INST_WIDTH`, 32, instruction width
- `RESET_PC`, 0, first fetch address after reset
- `NOP_INST`, 32'h00000013, value driven on `inst` when the buffer is empty

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `PCSrc` in 1: redirect strobe from EX (taken branch)
- `branch_addr` in ADDR_WIDTH: redirect target from EX
- `stall` in 1: IF/ID hold from hazard unit; buffer not consumed this cycle
- `imem_req_valid` out 1: fetch request valid
- `imem_req_addr` out ADDR_WIDTH: fetch address
- `imem_req_ready` in 1: memory accepts request
- `imem_resp_valid` in 1: response valid
- `imem_resp_data` in INST_WIDTH: fetched instruction
- `imem_resp_ready` out 1: block accepts response
- `inst` out INST_WIDTH: instruction to IF/ID
- `inst_addr` out ADDR_WIDTH: its address
- `inst_valid` out 1: `inst`/`inst_addr` hold a real instruction

## Operation
- Registers: `pc` (next fetch address), `fetch_addr` (address of outstanding request), state, one-entry output buffer (`inst`, `inst_addr`, `inst_valid`).
- Consume: buffer consumed on a rising edge with `inst_valid && !stall`.
- States:
  - REQ: `imem_req_valid`=1, `imem_req_addr`=`pc`. On `imem_req_ready`: `fetch_addr`<=`pc`, `pc`<=`pc`+4, go WAIT.
  - WAIT: `imem_resp_ready` = `!inst_valid || !stall`. On response handshake: buffer <= {`imem_resp_data`, `fetch_addr`, 1}; go REQ.
  - DROP: `imem_resp_ready`=1; response handshake discarded; go REQ.
- Redirect (`PCSrc`=1), highest priority, any state:
  - `pc`<=`branch_addr`; `inst_valid`<=0, `inst`<=NOP_INST.
  - REQ without ready: stay REQ; next cycle address = target.
  - REQ with ready same cycle: wrong-path request issued, go DROP; `pc` still <= `branch_addr` (no +4).
  - WAIT, no response this cycle: go DROP.
  - WAIT with response handshake this cycle: response discarded, go REQ.
  - DROP: stay DROP (or REQ if response arrives this cycle).
- Buffer without new fill: consumed -> `inst_valid`<=0, `inst`<=NOP_INST, `inst_addr` holds. Not consumed -> holds.
- Fill and consume same edge: new instruction replaces old.
- `imem_req_addr` stable while `imem_req_valid && !imem_req_ready`, except after a redirect; memory acts only on handshake cycles.
- PC arithmetic modulo 2^ADDR_WIDTH; `pc`+4 wraps from all-ones-minus-3 to 0, no flag.

## Timing
- Reset (async assert): state REQ, `pc`=RESET_PC, `inst_valid`=0, `inst`=NOP_INST, `inst_addr`=0, `imem_req_valid`=0 and `imem_resp_ready`=0 while `rst_n`=0. First request in first cycle after deassert.
- Reset mid-fetch: outstanding request forgotten; instruction memory is reset by the same `rst_n`, so no stale response follows.
- Memory responds ≥1 cycle after request handshake; same-cycle responses not supported.
- Zero-wait memory: issue cycle N, response N+1, `inst_valid` at N+2, next issue N+2; steady state 1 instruction / 2 cycles.
- Redirect at cycle N: `inst_valid`=0 from N+1; target request visible at N+1 (from REQ/WAIT-with-response), or after the in-flight response drains (DROP).
- `stall` and buffer full: WAIT holds `imem_resp_ready`=0; memory must hold its response.

## Test plan
- Reset release, RESET_PC=0, zero-wait memory, `stall`=0 -> requests at 0,4,8; `inst_addr` 0,4,8 on alternate cycles with matching data, `inst_valid` pulses.
- `stall`=1 for 5 cycles with buffer holding addr 4 -> `inst`/`inst_addr` frozen, `imem_resp_ready`=0 for pending addr 8; released -> addr 8 delivered next fill, none lost or duplicated.
- `PCSrc`=1, `branch_addr`=0x100 while WAIT for addr 0x8 (3-cycle latency) -> DROP, 0x8 response discarded, next request 0x100, `inst_valid`=0 until 0x100 data.
- Redirect to 0x200 in same cycle as response handshake for 0xC -> 0xC never appears on `inst`; next request 0x200.
- Redirect to 0x40 in REQ with `imem_req_ready`=1 -> wrong-path response discarded; following requests 0x40, 0x44.
- `rst_n` low for 1 cycle mid-WAIT at pc 0x20 -> outputs at reset values immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one-outstanding fetches over a
// valid/ready handshake and buffers one instruction for IF/ID; EX redirects win.
module if_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [INST_WIDTH-1:0] NOP_INST   = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  PCSrc,
    input  logic [ADDR_WIDTH-1:0] branch_addr,
    input  logic                  stall,
    output logic                  imem_req_valid,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_resp_valid,
    input  logic [INST_WIDTH-1:0] imem_resp_data,
    output logic                  imem_resp_ready,
    output logic [INST_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_addr,
    output logic                  inst_valid
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(3'd4);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_fetch_addr;
    logic [INST_WIDTH-1:0] r_inst;
    logic [ADDR_WIDTH-1:0] r_inst_addr;
    logic                  r_inst_valid;
    logic                  w_req_valid;
    logic                  w_resp_ready;
    logic                  w_req_hs;
    logic                  w_resp_hs;
    logic                  w_consume;
    logic                  w_fill;

    assign w_req_hs  = w_req_valid && imem_req_ready;
    assign w_resp_hs = imem_resp_valid && w_resp_ready;
    assign w_consume = r_inst_valid && !stall;
    // A response arriving in the redirect cycle is wrong-path and is dropped.
    assign w_fill    = (r_state == ST_WAIT) && w_resp_hs && !PCSrc;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; redirects turn any in-flight fetch into a drop.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_REQ: begin
                if (w_req_hs) begin
                    w_state_nxt = PCSrc ? ST_DROP : ST_WAIT;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (w_resp_hs) begin
                    w_state_nxt = ST_REQ;
                end else begin
                    w_state_nxt = PCSrc ? ST_DROP : ST_WAIT;
                end
            end
            ST_DROP: begin
                if (w_resp_hs) begin
                    w_state_nxt = ST_REQ;
                end else begin
                    w_state_nxt = ST_DROP;
                end
            end
            default: w_state_nxt = ST_REQ;
        endcase
    end

    // Handshake outputs decoded from state; a full, stalled buffer back-pressures memory.
    always_comb begin
        w_req_valid  = 1'b0;
        w_resp_ready = 1'b0;
        case (r_state)
            ST_REQ:  w_req_valid  = 1'b1;
            ST_WAIT: w_resp_ready = !r_inst_valid || !stall;
            ST_DROP: w_resp_ready = 1'b1;
            default: begin
                w_req_valid  = 1'b0;
                w_resp_ready = 1'b0;
            end
        endcase
    end

    // Handshakes are forced low combinationally while reset is held.
    assign imem_req_valid  = w_req_valid && rst_n;
    assign imem_resp_ready = w_resp_ready && rst_n;
    assign imem_req_addr   = r_pc;

    // PC and outstanding-request address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_fetch_addr <= {ADDR_WIDTH{1'b0}};
        end else begin
            if (PCSrc) begin
                r_pc <= branch_addr;
            end else if (w_req_hs) begin
                r_pc <= r_pc + PC_STEP;
            end else begin
                r_pc <= r_pc;
            end
            if (w_req_hs) begin
                r_fetch_addr <= r_pc;
            end else begin
                r_fetch_addr <= r_fetch_addr;
            end
        end
    end

    // One-entry output buffer; a fill on the consume edge replaces the old entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst       <= NOP_INST;
            r_inst_addr  <= {ADDR_WIDTH{1'b0}};
            r_inst_valid <= 1'b0;
        end else if (PCSrc) begin
            r_inst       <= NOP_INST;
            r_inst_valid <= 1'b0;
        end else if (w_fill) begin
            r_inst       <= imem_resp_data;
            r_inst_addr  <= r_fetch_addr;
            r_inst_valid <= 1'b1;
        end else if (w_consume) begin
            r_inst       <= NOP_INST;
            r_inst_valid <= 1'b0;
        end else begin
            r_inst       <= r_inst;
            r_inst_addr  <= r_inst_addr;
            r_inst_valid <= r_inst_valid;
        end
    end

    assign inst       = r_inst;
    assign inst_addr  = r_inst_addr;
    assign inst_valid = r_inst_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a variable-latency instruction memory model.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        PCSrc;
    logic [31:0] branch_addr;
    logic        stall;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_ready;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        inst_valid;

    int          n_vec;
    int          n_err;
    int          lat;

    logic        m_pend;
    logic [31:0] m_addr;
    int          m_cnt;

    if_fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .PCSrc           (PCSrc),
        .branch_addr     (branch_addr),
        .stall           (stall),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_ready (imem_resp_ready),
        .inst            (inst),
        .inst_addr       (inst_addr),
        .inst_valid      (inst_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mkdata(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    // Memory: response valid 'lat' cycles after the request handshake, held until taken.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend <= 1'b0;
            m_addr <= 32'd0;
            m_cnt  <= 0;
        end else begin
            if (m_pend && m_cnt > 0) m_cnt <= m_cnt - 1;
            if (imem_resp_valid && imem_resp_ready) m_pend <= 1'b0;
            if (imem_req_valid && imem_req_ready) begin
                m_pend <= 1'b1;
                m_addr <= imem_req_addr;
                m_cnt  <= lat - 1;
            end
        end
    end

    assign imem_resp_valid = m_pend && (m_cnt == 0);
    assign imem_resp_data  = mkdata(m_addr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        rst_n          = 1'b0;
        PCSrc          = 1'b0;
        branch_addr    = 32'd0;
        stall          = 1'b0;
        imem_req_ready = 1'b1;
        step();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        lat   = 1;
        rst_n          = 1'b0;
        PCSrc          = 1'b0;
        branch_addr    = 32'd0;
        stall          = 1'b0;
        imem_req_ready = 1'b1;
        step();
        step();

        // Reset state
        chk1 ("rst_req_valid", imem_req_valid, 1'b0);
        chk1 ("rst_resp_ready", imem_resp_ready, 1'b0);
        chk1 ("rst_inst_valid", inst_valid, 1'b0);
        chk32("rst_inst", inst, NOP);
        chk32("rst_inst_addr", inst_addr, 32'd0);
        rst_n = 1'b1;
        #1;
        chk1 ("rel_req_valid", imem_req_valid, 1'b1);
        chk32("rel_req_addr", imem_req_addr, 32'd0);

        // Zero-wait streaming: 0, 4 delivered on alternate cycles, request 8 issued
        for (int k = 0; k < 2; k++) begin
            step();
            chk1("t1_wait_ivalid", inst_valid, 1'b0);
            chk1("t1_wait_rready", imem_resp_ready, 1'b1);
            chk1("t1_wait_qvalid", imem_req_valid, 1'b0);
            step();
            chk1 ("t1_ivalid", inst_valid, 1'b1);
            chk32("t1_iaddr", inst_addr, 32'(k * 4));
            chk32("t1_inst", inst, mkdata(32'(k * 4)));
            chk32("t1_next_req", imem_req_addr, 32'(k * 4 + 4));
        end

        // Stall for 5 cycles with addr 4 buffered and addr 8 pending
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk32("t2_hold_iaddr", inst_addr, 32'h4);
            chk32("t2_hold_inst", inst, mkdata(32'h4));
            chk1 ("t2_hold_ivalid", inst_valid, 1'b1);
            chk1 ("t2_rready_low", imem_resp_ready, 1'b0);
        end
        stall = 1'b0;
        #1;
        chk1("t2_rready_rel", imem_resp_ready, 1'b1);
        step();
        chk32("t2_iaddr8", inst_addr, 32'h8);
        chk32("t2_inst8", inst, mkdata(32'h8));
        chk1 ("t2_ivalid8", inst_valid, 1'b1);
        chk32("t2_req_c", imem_req_addr, 32'hC);
        step();
        chk1("t2_consumed", inst_valid, 1'b0);
        step();
        chk32("t2_iaddr_c", inst_addr, 32'hC);

        // Redirect to 0x100 while waiting on addr 8 (latency 3)
        lat = 3;
        reset_dut();
        repeat (8) step();
        chk32("t3_iaddr4", inst_addr, 32'h4);
        chk32("t3_req8", imem_req_addr, 32'h8);
        step();
        chk1("t3_wait_ivalid", inst_valid, 1'b0);
        PCSrc = 1'b1;
        branch_addr = 32'h100;
        step();
        PCSrc = 1'b0;
        chk1("t3_drop_qvalid", imem_req_valid, 1'b0);
        chk1("t3_drop_rready", imem_resp_ready, 1'b1);
        step();
        chk1("t3_drop2_qvalid", imem_req_valid, 1'b0);
        step();
        chk1 ("t3_req_valid", imem_req_valid, 1'b1);
        chk32("t3_req_100", imem_req_addr, 32'h100);
        chk1 ("t3_ivalid0", inst_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk1("t3_no_inst", inst_valid, 1'b0);
        end
        step();
        chk1 ("t3_ivalid", inst_valid, 1'b1);
        chk32("t3_iaddr", inst_addr, 32'h100);
        chk32("t3_inst", inst, mkdata(32'h100));

        // Redirect to 0x200 on the response-handshake cycle for 0xC
        lat = 1;
        reset_dut();
        repeat (6) step();
        chk32("t4_iaddr8", inst_addr, 32'h8);
        chk32("t4_req_c", imem_req_addr, 32'hC);
        step();
        chk1("t4_resp_rdy", imem_resp_ready, 1'b1);
        PCSrc = 1'b1;
        branch_addr = 32'h200;
        step();
        PCSrc = 1'b0;
        chk1 ("t4_ivalid0", inst_valid, 1'b0);
        chk1 ("t4_qvalid", imem_req_valid, 1'b1);
        chk32("t4_req_200", imem_req_addr, 32'h200);
        step();
        chk1("t4_ivalid1", inst_valid, 1'b0);
        step();
        chk1 ("t4_ivalid", inst_valid, 1'b1);
        chk32("t4_iaddr", inst_addr, 32'h200);
        chk32("t4_inst", inst, mkdata(32'h200));

        // Redirect to 0x40 in REQ with ready asserted
        reset_dut();
        PCSrc = 1'b1;
        branch_addr = 32'h40;
        step();
        PCSrc = 1'b0;
        chk1("t5_drop_qvalid", imem_req_valid, 1'b0);
        chk1("t5_drop_rready", imem_resp_ready, 1'b1);
        step();
        chk1 ("t5_ivalid0", inst_valid, 1'b0);
        chk32("t5_req_40", imem_req_addr, 32'h40);
        step();
        step();
        chk32("t5_iaddr40", inst_addr, 32'h40);
        chk32("t5_inst40", inst, mkdata(32'h40));
        chk32("t5_req_44", imem_req_addr, 32'h44);
        step();
        step();
        chk32("t5_iaddr44", inst_addr, 32'h44);

        // Redirect in REQ without ready, address hold, PC wrap
        reset_dut();
        imem_req_ready = 1'b0;
        PCSrc = 1'b1;
        branch_addr = 32'hFFFF_FFFC;
        step();
        PCSrc = 1'b0;
        chk1 ("t6_qvalid", imem_req_valid, 1'b1);
        chk32("t6_req_tgt", imem_req_addr, 32'hFFFF_FFFC);
        step();
        chk32("t6_req_hold", imem_req_addr, 32'hFFFF_FFFC);
        imem_req_ready = 1'b1;
        step();
        step();
        chk32("t6_iaddr", inst_addr, 32'hFFFF_FFFC);
        chk32("t6_wrap", imem_req_addr, 32'h0);

        // Reset mid-WAIT with pc 0x20
        reset_dut();
        imem_req_ready = 1'b0;
        PCSrc = 1'b1;
        branch_addr = 32'h18;
        step();
        PCSrc = 1'b0;
        imem_req_ready = 1'b1;
        step();
        step();
        chk32("t7_iaddr18", inst_addr, 32'h18);
        chk32("t7_req_1c", imem_req_addr, 32'h1C);
        stall = 1'b1;
        step();
        chk1 ("t7_wait_rready", imem_resp_ready, 1'b0);
        chk32("t7_pc20", imem_req_addr, 32'h20);
        rst_n = 1'b0;
        #1;
        chk1 ("t7_rst_qvalid", imem_req_valid, 1'b0);
        chk1 ("t7_rst_rready", imem_resp_ready, 1'b0);
        chk1 ("t7_rst_ivalid", inst_valid, 1'b0);
        chk32("t7_rst_inst", inst, NOP);
        chk32("t7_rst_iaddr", inst_addr, 32'd0);
        stall = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        chk1 ("t7_rel_qvalid", imem_req_valid, 1'b1);
        chk32("t7_rel_req", imem_req_addr, 32'd0);
        step();
        step();
        chk1 ("t7_ivalid", inst_valid, 1'b1);
        chk32("t7_iaddr0", inst_addr, 32'd0);
        chk32("t7_inst0", inst, mkdata(32'd0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
